acc_frame_serializer: RTL
=========================

Name: acc_frame_serializer

Overview:
- Consumes the parallel accumulation results produced once per decimation period: SA I/Q and CML I/Q, ACC_WIDTH bits each.
- Buffers one frame and shifts it off-chip MSB-first as a framed bitstream, with serial_start marking the first bit.
- Sits between the accumulator core and the serialStart/serialOut output pads.
- The accumulator cannot stall, so frames arriving while the buffer is occupied are dropped and counted.

Parameters:
- ACC_WIDTH, 16, width of each accumulated word.
- NUM_WORDS, 4, words per frame (order: SA_I, SA_Q, CML_I, CML_Q).
- GAP_BITS, 2, minimum idle bit-times between frames; serial_out held 0 during the gap.

Ports:
- clk  input  1  serial bit clock; all logic on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- acc_valid  input  1  one-cycle strobe: acc_data holds a new frame.
- acc_data  input  NUM_WORDS*ACC_WIDTH  frame; word 0 (SA_I) in the MSBs.
- serial_out  output  1  registered serial data, MSB of word 0 first.
- serial_start  output  1  registered; high only during the first bit of a frame.
- busy  output  1  shifter in SHIFT, CRC or GAP state.
- buf_full  output  1  holding buffer occupied (the inverse of ready).
- drop_count  output  8  saturating count of dropped frames.

Behaviour:
- Reset (async, reset_n=0): serial_out=0, serial_start=0, busy=0, buf_full=0, drop_count=0, FSM=IDLE, bit counter=0, CRC=0.
- Storage: one holding register (HOLD) plus one shift register (SR).
- Accept: acc_valid=1 with HOLD empty, or HOLD being transferred to SR in the same cycle → HOLD<=acc_data, buf_full=1 next cycle.
- Drop: acc_valid=1 while HOLD is full and not being transferred → frame discarded; drop_count+1, saturating at 255.
- FSM states: IDLE, SHIFT, CRC (only with the optional feature), GAP.
  - IDLE: if buf_full → SR<=HOLD, HOLD freed, go to SHIFT. On the same edge serial_out<=SR MSB and serial_start<=1. Otherwise serial_out=0.
  - SHIFT: one bit per clock; serial_start=0 after the first bit. After bit NUM_WORDS*ACC_WIDTH-1 → CRC if enabled, else GAP.
  - GAP: serial_out=0 for GAP_BITS cycles, then back to IDLE. With GAP_BITS=0, GAP is skipped; a pending HOLD loads directly and frames run back-to-back.
- Latency: strobe at edge k → buf_full visible after k → first bit with serial_start=1 visible after edge k+1 (when idle).
- Frame period in clocks: NUM_WORDS*ACC_WIDTH (+8 with CRC) + GAP_BITS + 1 (the IDLE load cycle). A second strobe arriving mid-frame is held and sent right after the gap.
- Bit counter width: $clog2(NUM_WORDS*ACC_WIDTH+8). Counter wraps to 0 on entering GAP.
- busy=1 in SHIFT, CRC and GAP.
- Reset asserted mid-frame: stream aborts immediately, serial_out=0, HOLD contents invalidated. No partial-frame resumption.

Optional Feature:
- Macro: ACC_FRAME_CRC_EN.
- Defined:
  - CRC-8, polynomial x^8+x^2+x+1 (0x07), init 0x00, no reflection, no final XOR.
  - Computed serially over all frame data bits as they are shifted.
  - Appended MSB-first in state CRC (8 clocks).
  - CRC register clears on each IDLE→SHIFT load.
- Not defined: CRC state, CRC register and its logic absent; SHIFT goes directly to GAP.

Decomposition:
- Shared package acc_pkg holds:
  - the FSM state enum (IDLE, SHIFT, CRC, GAP);
  - the channel index constants CH_SA_I=0, CH_SA_Q=1, CH_CML_I=2, CH_CML_Q=3;
  - CRC_POLY=8'h07 and CRC_WIDTH=8.
- One natural sub-module: crc8_serial. Inputs clk, reset_n, clear, en, bit_in; output crc[7:0]. Instantiated only under ACC_FRAME_CRC_EN.

Test Plan:
- Single frame, defaults, no CRC: strobe acc_data=64'h8001_0000_FFFF_1234 → first bit 1 with serial_start=1 two edges after the strobe. 64 bits recovered equal to the input. serial_out=0 for 2 clocks after. busy drops after 66 clocks.
- Back-to-back: second strobe 10 clocks after the first → buf_full=1. Frame 2 starts exactly 3 clocks after frame 1's last bit (2 gap + 1 load). drop_count=0.
- Overrun: three strobes within one frame time → frames 1 and 2 transmitted, third dropped, drop_count=1. 300 further overrun strobes → drop_count saturates at 255.
- Simultaneous load/accept: strobe on the exact edge HOLD transfers to SR → new frame accepted, not dropped.
- Reset mid-frame: reset_n low at bit 20 → outputs 0 asynchronously, no serial_start. After release with no strobe, serial_out stays 0.
- CRC build (ACC_FRAME_CRC_EN): acc_data all zero → trailing CRC 8'h00. Word 0=16'h0001, others 0 → CRC matches the golden CRC-8/0x07 model, 72 bits total.

Source files
------------

// File: rtl/acc_pkg.sv
// Shared types and constants for the accumulator frame serializer.
// FSM states, channel order and the CRC-8 step used by crc8_serial.
package acc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CRC   = 2'd2,
        ST_GAP   = 2'd3
    } acc_state_e;

    localparam int CH_SA_I  = 0;
    localparam int CH_SA_Q  = 1;
    localparam int CH_CML_I = 2;
    localparam int CH_CML_Q = 3;

    localparam int               CRC_WIDTH = 8;
    localparam logic [CRC_WIDTH-1:0] CRC_POLY  = 8'h07;

    // One serial CRC step: MSB-first, no reflection.
    function automatic logic [CRC_WIDTH-1:0] crc8_step(
        input logic [CRC_WIDTH-1:0] c,
        input logic                 b
    );
        logic fb;
        fb = c[CRC_WIDTH-1] ^ b;
        return {c[CRC_WIDTH-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
    endfunction

endpackage

// File: rtl/crc8_serial.sv
// Bit-serial CRC-8 (poly 0x07, init 0) over the outgoing data bits.
// A clear together with en restarts the CRC from zero with bit_in.
module crc8_serial
    import acc_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clear,
    input  logic                 en,
    input  logic                 bit_in,
    output logic [CRC_WIDTH-1:0] crc
);

    logic [CRC_WIDTH-1:0] base;

    assign base = clear ? '0 : crc;

    // CRC register: clear has priority as the seed, en folds in one bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            crc <= '0;
        end else if (en) begin
            crc <= crc8_step(base, bit_in);
        end else if (clear) begin
            crc <= '0;
        end
    end

endmodule

// File: rtl/acc_frame_serializer.sv
// Buffers one accumulator frame and shifts it out MSB-first with a start flag.
// Optional trailing CRC-8 when ACC_FRAME_CRC_EN is defined.
module acc_frame_serializer
    import acc_pkg::*;
#(
    parameter int ACC_WIDTH = 16,
    parameter int NUM_WORDS = 4,
    parameter int GAP_BITS  = 2
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           acc_valid,
    input  logic [NUM_WORDS*ACC_WIDTH-1:0] acc_data,
    output logic                           serial_out,
    output logic                           serial_start,
    output logic                           busy,
    output logic                           buf_full,
    output logic [7:0]                     drop_count
);

    localparam int FRAME_BITS = NUM_WORDS * ACC_WIDTH;
    localparam int CNT_W      = $clog2(FRAME_BITS + 8);

    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(FRAME_BITS - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  =
        CNT_W'((GAP_BITS > 0) ? (GAP_BITS - 1) : 0);

    acc_state_e            state;
    acc_state_e            state_next;
    logic [FRAME_BITS-1:0] hold;
    logic [FRAME_BITS-1:0] sr;
    logic [FRAME_BITS-1:0] sr_next;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      cnt_next;
    logic                  out_next;
    logic                  start_next;
    logic                  load;
    logic                  accept;
    logic                  drop;

`ifdef ACC_FRAME_CRC_EN
    localparam logic [CNT_W-1:0] FIRST_CRC = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] LAST_CRC  = CNT_W'(FRAME_BITS + 7);

    logic                 crc_clear;
    logic                 crc_en;
    logic                 crc_bit;
    logic [CRC_WIDTH-1:0] crc;

    crc8_serial u_crc (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (crc_clear),
        .en      (crc_en),
        .bit_in  (crc_bit),
        .crc     (crc)
    );
`endif

    // HOLD hands over to SR on the IDLE load cycle; a strobe on that
    // same edge refills HOLD instead of being dropped.
    assign load   = (state == ST_IDLE) && buf_full;
    assign accept = acc_valid && (!buf_full || load);
    assign drop   = acc_valid && buf_full && !load;
    assign busy   = (state != ST_IDLE);

    // Holding buffer and saturating drop counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold       <= '0;
            buf_full   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (accept) begin
                hold     <= acc_data;
                buf_full <= 1'b1;
            end else if (load) begin
                buf_full <= 1'b0;
            end
            if (drop && (drop_count != 8'hFF)) begin
                drop_count <= drop_count + 8'd1;
            end
        end
    end

    // FSM state, shift register, bit counter and registered pad outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            sr           <= '0;
            cnt          <= '0;
            serial_out   <= 1'b0;
            serial_start <= 1'b0;
        end else begin
            state        <= state_next;
            sr           <= sr_next;
            cnt          <= cnt_next;
            serial_out   <= out_next;
            serial_start <= start_next;
        end
    end

    // Next-state and next-output decode; idle line level is 0.
    always_comb begin
        state_next = state;
        sr_next    = sr;
        cnt_next   = cnt;
        out_next   = 1'b0;
        start_next = 1'b0;
`ifdef ACC_FRAME_CRC_EN
        crc_clear  = 1'b0;
        crc_en     = 1'b0;
        crc_bit    = 1'b0;
`endif
        unique case (state)
            ST_IDLE: begin
                if (buf_full) begin
                    state_next = ST_SHIFT;
                    sr_next    = hold << 1;
                    cnt_next   = '0;
                    out_next   = hold[FRAME_BITS-1];
                    start_next = 1'b1;
`ifdef ACC_FRAME_CRC_EN
                    crc_clear  = 1'b1;
                    crc_en     = 1'b1;
                    crc_bit    = hold[FRAME_BITS-1];
`endif
                end
            end
            ST_SHIFT: begin
                if (cnt == LAST_DATA) begin
`ifdef ACC_FRAME_CRC_EN
                    state_next = ST_CRC;
                    cnt_next   = FIRST_CRC;
                    out_next   = crc[CRC_WIDTH-1];
                    sr_next    = {crc[CRC_WIDTH-2:0],
                                  {(FRAME_BITS-CRC_WIDTH+1){1'b0}}};
`else
                    state_next = (GAP_BITS == 0) ? ST_IDLE : ST_GAP;
                    cnt_next   = '0;
`endif
                end else begin
                    cnt_next = cnt + 1'b1;
                    out_next = sr[FRAME_BITS-1];
                    sr_next  = sr << 1;
`ifdef ACC_FRAME_CRC_EN
                    crc_en   = 1'b1;
                    crc_bit  = sr[FRAME_BITS-1];
`endif
                end
            end
`ifdef ACC_FRAME_CRC_EN
            ST_CRC: begin
                if (cnt == LAST_CRC) begin
                    state_next = (GAP_BITS == 0) ? ST_IDLE : ST_GAP;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                    out_next = sr[FRAME_BITS-1];
                    sr_next  = sr << 1;
                end
            end
`endif
            ST_GAP: begin
                if (cnt == GAP_LAST) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

endmodule
